// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (equivalent inverse cipher form). One
// inverse-round datapath is reused for NR rounds; round keys are fetched from
// an external decryption key store through rk_idx / rk.

package aes_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] a;
        a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    // Inverse T-table entry for byte position pos (Td0..Td3 are byte rotations).
    function automatic logic [31:0] td(input logic [7:0] x, input logic [1:0] pos);
        logic [7:0]  s;
        logic [31:0] col;
        s   = inv_sbox(x);
        col = {gmul(s, 8'h0e), gmul(s, 8'h09), gmul(s, 8'h0d), gmul(s, 8'h0b)};
        case (pos)
            2'd0:    return col;
            2'd1:    return {col[7:0], col[31:8]};
            2'd2:    return {col[15:0], col[31:16]};
            default: return {col[23:0], col[31:24]};
        endcase
    endfunction

endpackage

// Registered inverse T-table lookup of the four bytes of one state word.
module inv_table_lookup (
    input  logic        clk,
    input  logic [31:0] w,
    output logic [31:0] q0,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic [31:0] q3
);
    import aes_inv_pkg::*;

    // Lookup results land one cycle after the word is presented.
    always_ff @(posedge clk) begin
        q0 <= td(w[31:24], 2'd0);
        q1 <= td(w[23:16], 2'd1);
        q2 <= td(w[15:8],  2'd2);
        q3 <= td(w[7:0],   2'd3);
    end
endmodule

// Registered inverse S-box of the four bytes of one state word.
module inv_S4 (
    input  logic        clk,
    input  logic [31:0] w,
    output logic [31:0] b
);
    import aes_inv_pkg::*;

    // Byte substitutions land one cycle after the word is presented.
    always_ff @(posedge clk) begin
        b <= {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    end
endmodule

module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_decrypt_iter: NR must be 10, 12 or 14");
    end

    typedef enum logic [2:0] {IDLE, RND_A, RND_B, FIN_A, FIN_B, DONE} state_t;

    localparam logic [3:0] LAST_RND = 4'(NR - 1);
    localparam logic [3:0] FIN_IDX  = 4'(NR);

    state_t       st, st_nxt;
    logic [3:0]   rnd;
    logic [127:0] blk_p0;
    logic [31:0]  q [4][4];
    logic [31:0]  b [4];
    logic [127:0] rnd_z;
    logic [127:0] fin_z;
    logic         accept;
    logic         ld_rnd;
    logic         ld_fin;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        inv_table_lookup u_tl (
            .clk (clk),
            .w   (blk_p0[127-32*i -: 32]),
            .q0  (q[i][0]),
            .q1  (q[i][1]),
            .q2  (q[i][2]),
            .q3  (q[i][3])
        );
        inv_S4 u_s4 (
            .clk (clk),
            .w   (blk_p0[127-32*i -: 32]),
            .b   (b[i])
        );
    end

    // Inverse ShiftRows is folded into which word feeds each byte slot.
    assign rnd_z = {q[0][0] ^ q[3][1] ^ q[2][2] ^ q[1][3],
                    q[1][0] ^ q[0][1] ^ q[3][2] ^ q[2][3],
                    q[2][0] ^ q[1][1] ^ q[0][2] ^ q[3][3],
                    q[3][0] ^ q[2][1] ^ q[1][2] ^ q[0][3]} ^ rk;

    assign fin_z = {b[0][31:24], b[3][23:16], b[2][15:8], b[1][7:0],
                    b[1][31:24], b[0][23:16], b[3][15:8], b[2][7:0],
                    b[2][31:24], b[1][23:16], b[0][15:8], b[3][7:0],
                    b[3][31:24], b[2][23:16], b[1][15:8], b[0][7:0]} ^ rk;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    // Next-state decode, handshake outputs and round-key index.
    always_comb begin
        st_nxt    = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = 4'd0;
        accept    = 1'b0;
        ld_rnd    = 1'b0;
        ld_fin    = 1'b0;
        case (st)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    st_nxt = RND_A;
                end
            end
            RND_A: begin
                rk_idx = rnd;
                st_nxt = RND_B;
            end
            RND_B: begin
                rk_idx = rnd;
                ld_rnd = 1'b1;
                st_nxt = (rnd == LAST_RND) ? FIN_A : RND_A;
            end
            FIN_A: begin
                rk_idx = FIN_IDX;
                st_nxt = FIN_B;
            end
            FIN_B: begin
                rk_idx = FIN_IDX;
                ld_fin = 1'b1;
                st_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Block state, round counter and plaintext register.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_p0   <= '0;
            rnd      <= 4'd0;
            out_data <= '0;
        end else begin
            if (accept) begin
                blk_p0 <= in_data ^ rk;
                rnd    <= 4'd1;
            end
            if (ld_rnd) begin
                blk_p0 <= rnd_z;
                if (rnd != LAST_RND) rnd <= rnd + 4'd1;
            end
            if (ld_fin) out_data <= fin_z;
        end
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 / SP800-38A vectors at NR=10
// and NR=14, latency, rk_idx order, backpressure, reset and back-to-back issue.
module tb_aes_decrypt_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic         sel;

    logic         in_valid10, in_ready10, out_valid10, busy10;
    logic [3:0]   rk_idx10;
    logic [127:0] rk10, out_data10;
    logic         in_valid14, in_ready14, out_valid14, busy14;
    logic [3:0]   rk_idx14;
    logic [127:0] rk14, out_data14;

    logic         s_in_ready, s_out_valid, s_busy;
    logic [3:0]   s_rk_idx;
    logic [127:0] s_out_data;

    logic [127:0] dk10 [0:15];
    logic [127:0] dk14 [0:15];

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc [0:15];

    assign in_valid10 = in_valid & ~sel;
    assign in_valid14 = in_valid & sel;
    assign rk10 = dk10[rk_idx10];
    assign rk14 = dk14[rk_idx14];
    assign s_in_ready  = sel ? in_ready14  : in_ready10;
    assign s_out_valid = sel ? out_valid14 : out_valid10;
    assign s_busy      = sel ? busy14      : busy10;
    assign s_rk_idx    = sel ? rk_idx14    : rk_idx10;
    assign s_out_data  = sel ? out_data14  : out_data10;

    aes_decrypt_iter #(.NR(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_data(in_data), .rk_idx(rk_idx10), .rk(rk10), .out_valid(out_valid10),
        .out_ready(out_ready), .out_data(out_data10), .busy(busy10)
    );

    aes_decrypt_iter #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data), .rk_idx(rk_idx14), .rk(rk14), .out_valid(out_valid14),
        .out_ready(out_ready), .out_data(out_data14), .busy(busy14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and accept-time log for the selected core.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && s_in_ready && acc_n < 16) begin
            acc_cyc[acc_n] <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- key store model (forward key expansion, InvMixColumns on middle keys)
    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01; p = x;
        for (int i = 1; i < 8; i++) begin
            p = m_mul(p, p);
            r = m_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] m_subw(input logic [31:0] w);
        return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] m_imix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {m_mul(a0,8'h0e) ^ m_mul(a1,8'h0b) ^ m_mul(a2,8'h0d) ^ m_mul(a3,8'h09),
                m_mul(a0,8'h09) ^ m_mul(a1,8'h0e) ^ m_mul(a2,8'h0b) ^ m_mul(a3,8'h0d),
                m_mul(a0,8'h0d) ^ m_mul(a1,8'h09) ^ m_mul(a2,8'h0e) ^ m_mul(a3,8'h0b),
                m_mul(a0,8'h0b) ^ m_mul(a1,8'h0d) ^ m_mul(a2,8'h09) ^ m_mul(a3,8'h0e)};
    endfunction

    task automatic build_dk(input logic [255:0] key, input int nk, input int nr, input bit for14);
        logic [31:0]  w [0:59];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] kr, v;
        int           idx;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = m_xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = m_subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            kr  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            idx = nr - r;
            if (idx == 0 || idx == nr) v = kr;
            else v = {m_imix_col(kr[127:96]), m_imix_col(kr[95:64]),
                      m_imix_col(kr[63:32]), m_imix_col(kr[31:0])};
            if (for14) dk14[idx] = v;
            else       dk10[idx] = v;
        end
    endtask

    // ---- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One decryption: accept, latency, rk_idx order, result, optional hold, release.
    task automatic run(input logic [127:0] ct, input logic [127:0] pt, input int hold, input string tag);
        int nr, lat;
        bit seq_ok, stable;
        nr = sel ? 14 : 10;
        in_data = ct; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk({tag, " in_ready@accept"}, 128'(s_in_ready), 128'(1));
        chk({tag, " rk_idx@accept"}, 128'(s_rk_idx), 128'(0));
        tick();
        in_valid = 1'b0;
        in_data  = ~ct;
        lat = 1; seq_ok = 1'b1;
        while (!s_out_valid && lat < 60) begin
            if (s_rk_idx !== 4'((lat + 1) / 2)) seq_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'(2*nr + 1));
        chk({tag, " rk_idx order"}, 128'(seq_ok), 128'(1));
        chk({tag, " out_data"}, s_out_data, pt);
        chk({tag, " in_ready@done"}, 128'(s_in_ready), 128'(0));
        stable = 1'b1;
        in_valid = 1'b1;
        in_data  = {4{$urandom}};
        for (int i = 0; i < hold; i++) begin
            tick();
            if (s_out_valid !== 1'b1 || s_out_data !== pt || s_in_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) chk({tag, " hold stable"}, 128'(stable), 128'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid@release"}, 128'(s_out_valid), 128'(0));
        chk({tag, " in_ready@release"}, 128'(s_in_ready), 128'(1));
        chk({tag, " busy@release"}, 128'(s_busy), 128'(0));
    endtask

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTA = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CTA = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PTB = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CTB = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        int  base, n;
        bit  quiet;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dk10[i] = '0;
            dk14[i] = '0;
        end
        build_dk({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1'b0);
        build_dk(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);

        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset in_ready", 128'(in_ready10), 128'(1));
        chk("reset out_valid", 128'(out_valid10), 128'(0));
        chk("reset busy", 128'(busy10), 128'(0));
        chk("reset rk_idx", 128'(rk_idx10), 128'(0));
        chk("reset out_data", out_data10, 128'h0);

        // rst and in_valid together: no accept
        rst = 1'b1; in_valid = 1'b1; in_data = CT1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst vs in_valid busy", 128'(busy10), 128'(0));

        run(CT1, PT1, 0, "v1");

        // reset in the middle of a decryption
        in_data = CT1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst busy", 128'(busy10), 128'(0));
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (out_valid10 !== 1'b0) quiet = 1'b0;
        end
        chk("midrst no out_valid", 128'(quiet), 128'(1));
        run(CT1, PT1, 0, "v1 after rst");

        // FIPS-197 appendix B key, with 50 cycles of backpressure
        build_dk({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, 1'b0);
        run(CT2, PT2, 50, "v2");

        // back-to-back issue with in_valid held high
        base = acc_n;
        in_data = CTA; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!s_out_valid && n < 60);
        chk("b2b first out_data", s_out_data, PTA);
        in_data = CTB;
        n = 0;
        do begin tick(); n++; end while (s_out_valid && n < 5);
        n = 0;
        do begin tick(); n++; end while (!s_out_valid && n < 60);
        chk("b2b second out_data", s_out_data, PTB);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("b2b accept count", 128'(acc_n - base), 128'(2));
        chk("b2b issue period", 128'(acc_cyc[base+1] - acc_cyc[base]), 128'(22));

        // AES-256 on the NR=14 core
        sel = 1'b1;
        #1;
        chk("nr14 idle", 128'(busy14), 128'(0));
        run(CT3, PT1, 0, "v14");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
